mod5_seq_checker: RTL and testbench
===================================

# mod5_seq_checker

Sequence checker for the output of a free-running mod-MOD counter (default mod-5: 0,1,2,3,4,0,...). It sits on the far side of the counter interface and samples the 3-bit count on qualified clock edges. It locks onto the sequence at the first 0, checks every later sample against the expected successor, and reports wraps and faults. It is used as an in-system monitor and as the scoreboard element in counter testbenches.

## Interface
- MOD, 5: counter modulus, 2..8; legal codes are 0..MOD-1
- WRAP_W, 8: width of the wrap counter
- ERR_W, 4: width of the error counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of counters and state
- en  in  1  sample qualifier; q_in is checked only on edges where en=1
- q_in  in  3  count value under check
- locked  out  1  1 while in LOCK
- state  out  2  00 HUNT, 01 LOCK, 10 FAULT
- exp_q  out  3  next expected value
- err  out  1  one-cycle pulse per mismatch
- wrap_pulse  out  1  one-cycle pulse per completed sequence
- wrap_cnt  out  WRAP_W  completed sequences, modulo 2^WRAP_W
- err_cnt  out  ERR_W  mismatches, saturating at 2^ERR_W-1

## Operation
- All outputs are registered. Reset and clr values: state=HUNT, locked=0, exp_q=0, err=0, wrap_pulse=0, wrap_cnt=0, err_cnt=0.
- Priority per edge: rst (async) > clr > en. When clr=1, the block ignores the sample.
- When en=0, the block holds state, exp_q and both counters, and err and wrap_pulse are 0.
- next(x) is x+1 if x<MOD-1, otherwise 0.
- HUNT, on en:
  - q_in=0: go to LOCK, exp_q<=next(0).
  - any other value: stay in HUNT. No error is raised.
- LOCK, on en:
  - q_in==exp_q: exp_q<=next(exp_q), stay in LOCK.
  - If the matching value is MOD-1, also pulse wrap_pulse and increment wrap_cnt. wrap_cnt wraps to 0 after all-ones.
  - q_in!=exp_q, including illegal codes >=MOD: go to FAULT, pulse err, increment err_cnt (saturating), exp_q<=0.
- FAULT, on en:
  - q_in=0: go to LOCK, exp_q<=next(0).
  - any other value: stay in FAULT. No further err pulses and no err_cnt increment.
  - One fault produces exactly one error count.
- A match at MOD-1 and the following 0 form a wrap. The sample 0 that achieves lock from HUNT or FAULT does not count as a wrap.
- MOD=2 degenerate case: the expected sequence is 0,1,0,1; a wrap is counted on each 1.

## Timing
- Sampling happens on the rising clk edge with en=1. state, locked and exp_q update on that edge.
- err and wrap_pulse go high in the cycle immediately after the sampling edge and last exactly one cycle.
  - Back-to-back wraps with continuous en at MOD=2 give pulses every 2 cycles.
- Latency from a bad sample to err: 1 clock. err_cnt reflects that error in the same cycle err is high.
- Lock latency: locked=1 in the cycle after the first sampled 0.
- rst asserted mid-operation clears all outputs immediately, without waiting for clk. The first sample after release is treated as HUNT.
- clr coincident with a mismatch or a wrap: clr wins. No pulse and no count.
- err_cnt at 2^ERR_W-1 stays there; err still pulses on each new fault.

## Test plan
- Reset with en=0 and q_in=3 → all outputs 0, state=HUNT. Release rst and drive q_in=3,4 with en=1 → still HUNT, err never pulses.
- Drive 0,1,2,3,4 three times, then a 0, en continuous → locked=1 from cycle 2, wrap_cnt=3, three wrap_pulses, err_cnt=0, exp_q=1 at end.
- Drive 0,1,3,4,0,1 → err pulses once after the 3, state=FAULT, err_cnt=1. The 4 gives no extra err. The 0 relocks, exp_q=2 after the final 1.
- Locked, drive illegal codes 7 then 6 → one err pulse, err_cnt=1, state=FAULT. Repeat 16 fault cycles with 0,5 pairs (ERR_W=4) → err_cnt saturates at 15 while err keeps pulsing.
- Drive 0,1,2 with en gaps of 3 idle cycles, q_in=7 during the gaps → gaps ignored, no err, exp_q=3.
- Locked at exp_q=4, assert rst asynchronously mid-cycle → outputs clear before the next edge. Separately, clr=1 with q_in=4 (a would-be wrap) → wrap_cnt=0, state=HUNT, no wrap_pulse.

Source files
------------

// File: rtl/mod5_seq_checker.sv
// mod5_seq_checker
// Monitors the output of a free-running mod-MOD counter. Locks onto the
// sequence at the first sampled 0, checks each later sample against the
// expected successor, and reports completed sequences (wraps) and faults.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear of state and counters (wins over en)
//   en         sample qualifier; q_in is checked only when en=1
//   q_in       count value under check
//   locked     1 while in LOCK
//   state      00 HUNT, 01 LOCK, 10 FAULT
//   exp_q      next expected value
//   err        one-cycle pulse per mismatch
//   wrap_pulse one-cycle pulse per completed sequence
//   wrap_cnt   completed sequences, modulo 2^WRAP_W
//   err_cnt    mismatches, saturating at 2^ERR_W-1
//
// state | meaning
// HUNT  | waiting for the first 0 after reset/clear
// LOCK  | following the sequence, checking every sample
// FAULT | mismatch seen, waiting for a 0 to relock
module mod5_seq_checker #(
  parameter int MOD    = 5,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [2:0]        q_in,
  output logic              locked,
  output logic [1:0]        state,
  output logic [2:0]        exp_q,
  output logic              err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    LOCK  = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [2:0]       LAST    = 3'(MOD - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t st;

  assign state = st;

  // exp_q only ever holds legal codes, so equality with LAST suffices.
  function automatic logic [2:0] nxt(input logic [2:0] x);
    return (x == LAST) ? 3'd0 : x + 3'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= HUNT;
      locked     <= 1'b0;
      exp_q      <= 3'd0;
      err        <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
    end else if (clr) begin
      st         <= HUNT;
      locked     <= 1'b0;
      exp_q      <= 3'd0;
      err        <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      err        <= 1'b0;
      wrap_pulse <= 1'b0;
      if (en) begin
        case (st)
          HUNT, FAULT: begin
            // Relock from FAULT does not count as a wrap.
            if (q_in == 3'd0) begin
              st     <= LOCK;
              locked <= 1'b1;
              exp_q  <= nxt(3'd0);
            end
          end
          LOCK: begin
            if (q_in == exp_q) begin
              exp_q <= nxt(exp_q);
              if (exp_q == LAST) begin
                wrap_pulse <= 1'b1;
                wrap_cnt   <= wrap_cnt + WRAP_W'(1);
              end
            end else begin
              st     <= FAULT;
              locked <= 1'b0;
              exp_q  <= 3'd0;
              err    <= 1'b1;
              if (err_cnt != ERR_MAX)
                err_cnt <= err_cnt + ERR_W'(1);
            end
          end
          default: begin
            st     <= HUNT;
            locked <= 1'b0;
            exp_q  <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod5_seq_checker.sv
// Scoreboard bench for mod5_seq_checker (MOD=5, WRAP_W=8, ERR_W=4).
// The stimulus process drives inputs on the falling edge, updates a
// behavioural model on the rising edge and queues the expected outputs;
// a monitor pops one entry per cycle and compares it with the DUT.
module tb_mod5_seq_checker;

  localparam int MOD = 5;

  logic       clk, rst, clr, en;
  logic [2:0] q_in;
  logic       locked, err, wrap_pulse;
  logic [1:0] state;
  logic [2:0] exp_q;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;

  mod5_seq_checker #(.MOD(MOD), .WRAP_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .q_in(q_in),
    .locked(locked), .state(state), .exp_q(exp_q), .err(err),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       lk;
    logic [2:0] ex;
    logic       er;
    logic       wp;
    logic [7:0] wc;
    logic [3:0] ec;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: mode 0 hunting, 1 locked, 2 faulted.
  int m_mode = 0;
  int m_exp  = 0;
  int m_wrap = 0;
  int m_err  = 0;

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic step(input logic e_in, input logic [2:0] q, input logic c);
    exp_t x;
    int er, wp;
    @(negedge clk);
    en = e_in; q_in = q; clr = c;
    @(posedge clk);
    er = 0; wp = 0;
    if (c) begin
      model_reset();
    end else if (e_in) begin
      if (m_mode != 1) begin
        if (q == 0) begin m_mode = 1; m_exp = 1 % MOD; end
      end else if (int'(q) == m_exp) begin
        if (m_exp == MOD - 1) begin wp = 1; m_wrap = (m_wrap + 1) % 256; end
        m_exp = (m_exp + 1) % MOD;
      end else begin
        er = 1;
        m_mode = 2;
        m_exp = 0;
        if (m_err < 15) m_err = m_err + 1;
      end
    end
    x.st = 2'(m_mode);
    x.lk = (m_mode == 1);
    x.ex = 3'(m_exp);
    x.er = 1'(er);
    x.wp = 1'(wp);
    x.wc = 8'(m_wrap);
    x.ec = 4'(m_err);
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (state !== e.st || locked !== e.lk || exp_q !== e.ex || err !== e.er ||
          wrap_pulse !== e.wp || wrap_cnt !== e.wc || err_cnt !== e.ec) begin
        miscompares++;
        $display("FAIL cycle %0d: got st=%0d lk=%0d exp=%0d err=%0d wp=%0d wc=%0d ec=%0d, want st=%0d lk=%0d exp=%0d err=%0d wp=%0d wc=%0d ec=%0d",
                 cyc, state, locked, exp_q, err, wrap_pulse, wrap_cnt, err_cnt,
                 e.st, e.lk, e.ex, e.er, e.wp, e.wc, e.ec);
      end
    end
  end

  task automatic check_cleared(input string name);
    vectors++;
    if (state !== 2'b00 || locked !== 1'b0 || exp_q !== 3'd0 || err !== 1'b0 ||
        wrap_pulse !== 1'b0 || wrap_cnt !== 8'd0 || err_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL %s: got st=%0d lk=%0d exp=%0d err=%0d wp=%0d wc=%0d ec=%0d, want all zero",
               name, state, locked, exp_q, err, wrap_pulse, wrap_cnt, err_cnt);
    end
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 3'(i), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; q_in = 3'd3;
    #23;
    check_cleared("reset_values");
    @(negedge clk);
    rst = 1'b0;

    // Non-zero values while hunting: no lock, no error.
    step(1, 3, 0); step(1, 4, 0);

    // Three full sequences then a 0.
    for (int k = 0; k < 3; k++) seq(5);
    step(1, 0, 0);

    // Skipped value -> single fault, relock.
    step(1, 1, 0); step(1, 3, 0); step(1, 4, 0); step(1, 0, 0); step(1, 1, 0);

    // Illegal codes while locked.
    step(1, 7, 0); step(1, 6, 0);

    // Saturate the error counter.
    for (int k = 0; k < 16; k++) begin step(1, 0, 0); step(1, 5, 0); end

    // Enable gaps with garbage on q_in.
    step(1, 0, 1);
    for (int v = 0; v < 3; v++) begin
      step(1, 3'(v), 0);
      for (int g = 0; g < 3; g++) step(0, 7, 0);
    end

    // Asynchronous reset while locked at exp_q=4.
    step(1, 0, 1);
    seq(4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_cleared("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // clr coincident with a would-be wrap.
    seq(4);
    step(1, 4, 1);
    step(1, 3, 0);

    // Wrap counter rollover past 255.
    step(1, 0, 1);
    for (int k = 0; k < 260; k++) seq(5);

    // Randomised traffic, biased toward correct sequences.
    for (int k = 0; k < 600; k++) begin
      logic       re, rc;
      logic [2:0] rq;
      re = ($urandom_range(99, 0) < 85);
      rc = ($urandom_range(99, 0) < 2);
      if (m_mode == 1 && $urandom_range(99, 0) < 80) rq = 3'(m_exp);
      else if (m_mode != 1 && $urandom_range(99, 0) < 40) rq = 3'd0;
      else rq = 3'($urandom_range(7, 0));
      step(re, rq, rc);
    end

    step(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
